// File: rtl/lb_arb_pkg.sv
`default_nettype none
//----------------------------------------------------------------------
// Package : lb_arb_pkg
// Shared widths, FSM encoding and defaults for the LocalBus arbiter.
// Rev     : 1.0
//----------------------------------------------------------------------
package lb_arb_pkg;
  localparam int LB_DW = 32;
  localparam int LB_AW = 32;
  localparam int NUM_M = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [LB_DW-1:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;
endpackage
`default_nettype wire

// File: rtl/lb_arbiter_if.sv
`default_nettype none
//----------------------------------------------------------------------
// Interface : lb_arbiter_if
// Two master request ports plus the shared LocalBus slave port.
// Rev       : 1.0
//----------------------------------------------------------------------
interface lb_arbiter_if;
  import lb_arb_pkg::*;

  logic             m0_req;
  logic             m0_wr;
  logic [LB_AW-1:0] m0_addr;
  logic [LB_DW-1:0] m0_wr_d;
  logic             m0_ack;
  logic [LB_DW-1:0] m0_rd_d;
  logic             m0_err;

  logic             m1_req;
  logic             m1_wr;
  logic [LB_AW-1:0] m1_addr;
  logic [LB_DW-1:0] m1_wr_d;
  logic             m1_ack;
  logic [LB_DW-1:0] m1_rd_d;
  logic             m1_err;

  logic             lb_wr;
  logic             lb_rd;
  logic [LB_AW-1:0] lb_addr;
  logic [LB_DW-1:0] lb_wr_d;
  logic [LB_DW-1:0] lb_rd_d;
  logic             lb_rd_rdy;

  // Arbiter view
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wr_d,
    input  m1_req, m1_wr, m1_addr, m1_wr_d,
    input  lb_rd_d, lb_rd_rdy,
    output m0_ack, m0_rd_d, m0_err,
    output m1_ack, m1_rd_d, m1_err,
    output lb_wr, lb_rd, lb_addr, lb_wr_d
  );

  // Environment view: masters plus the LocalBus slave
  modport master (
    output m0_req, m0_wr, m0_addr, m0_wr_d,
    output m1_req, m1_wr, m1_addr, m1_wr_d,
    output lb_rd_d, lb_rd_rdy,
    input  m0_ack, m0_rd_d, m0_err,
    input  m1_ack, m1_rd_d, m1_err,
    input  lb_wr, lb_rd, lb_addr, lb_wr_d
  );
endinterface
`default_nettype wire

// File: rtl/lb_rr_pick.sv
`default_nettype none
//----------------------------------------------------------------------
// Module : lb_rr_pick
// Round-robin picker: one-hot grant from req vector and last-grant pointer.
// Rev    : 1.0
//----------------------------------------------------------------------
module lb_rr_pick
  import lb_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_M-1:0] req,
  input  logic             upd,
  input  logic             upd_idx,
  output logic [NUM_M-1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (upd) last_d = upd_idx;
  end

  // Reset to "m1 granted last" so m0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

endmodule
`default_nettype wire

// File: rtl/lb_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------
// Module : lb_arbiter
// Serialises two LocalBus masters onto one slave port, with read timeout.
// Rev    : 1.0
//----------------------------------------------------------------------
module lb_arbiter
  import lb_arb_pkg::*;
#(
  parameter int               TO_BITS      = 8,
  parameter int               TIMEOUT      = 255,
  parameter logic [LB_DW-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic         clk_lb,
  input  logic         reset_l,
  lb_arbiter_if.slave  bus,
  output logic         busy
);

  logic [1:0]         state_q, state_d;
  logic               gidx_q, gidx_d;
  logic               wr_q, wr_d;
  logic [TO_BITS-1:0] cnt_q, cnt_d;
  logic               wr_stb_q, wr_stb_d;
  logic               rd_stb_q, rd_stb_d;
  logic [LB_AW-1:0]   addr_q, addr_d;
  logic [LB_DW-1:0]   wdata_q, wdata_d;
  logic [NUM_M-1:0]   ack_q, ack_d;
  logic [LB_DW-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;
  logic               err0_q, err0_d, err1_q, err1_d;
  logic               busy_q, busy_d;

  logic [NUM_M-1:0]   gnt;
  logic               timeout_hit;
  logic [LB_DW-1:0]   rdat;
  logic               rerr;

  lb_rr_pick u_pick (
    .clk     (clk_lb),
    .rst_n   (reset_l),
    .req     ({bus.m1_req, bus.m0_req}),
    .upd     (state_q == ST_DONE),
    .upd_idx (gidx_q),
    .gnt     (gnt)
  );

  assign timeout_hit = (state_q == ST_RD_WAIT) && (cnt_q >= TO_BITS'(TIMEOUT - 1));

  always_ff @(posedge clk_lb or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= ST_IDLE;
      gidx_q   <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|gnt) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = (wr_q || bus.lb_rd_rdy) ? ST_DONE : ST_RD_WAIT;
      ST_RD_WAIT: if (bus.lb_rd_rdy || timeout_hit) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from state_d so every port comes straight off a flop
  always_comb begin
    gidx_d  = gidx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdat    = '0;
    rerr    = 1'b0;

    if (state_q == ST_IDLE && |gnt) begin
      gidx_d  = gnt[1];
      wr_d    = gnt[1] ? bus.m1_wr   : bus.m0_wr;
      addr_d  = gnt[1] ? bus.m1_addr : bus.m0_addr;
      wdata_d = gnt[1] ? bus.m1_wr_d : bus.m0_wr_d;
    end

    if (state_q == ST_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == ST_RD_WAIT && !bus.lb_rd_rdy) begin
      cnt_d = timeout_hit ? TO_BITS'(TIMEOUT) : cnt_q + TO_BITS'(1);
    end

    if (!wr_q) begin
      if (bus.lb_rd_rdy) begin
        rdat = bus.lb_rd_d;
      end else if (timeout_hit) begin
        rdat = TIMEOUT_DATA;
        rerr = 1'b1;
      end
    end

    wr_stb_d = (state_d == ST_ISSUE) && wr_d;
    rd_stb_d = (state_d == ST_ISSUE) && !wr_d;
    ack_d[0] = (state_d == ST_DONE) && !gidx_q;
    ack_d[1] = (state_d == ST_DONE) && gidx_q;
    rd0_d    = ack_d[0] ? rdat : '0;
    rd1_d    = ack_d[1] ? rdat : '0;
    err0_d   = ack_d[0] && rerr;
    err1_d   = ack_d[1] && rerr;
    busy_d   = (state_d != ST_IDLE);
  end

  assign bus.lb_wr   = wr_stb_q;
  assign bus.lb_rd   = rd_stb_q;
  assign bus.lb_addr = addr_q;
  assign bus.lb_wr_d = wdata_q;
  assign bus.m0_ack  = ack_q[0];
  assign bus.m1_ack  = ack_q[1];
  assign bus.m0_rd_d = rd0_q;
  assign bus.m1_rd_d = rd1_q;
  assign bus.m0_err  = err0_q;
  assign bus.m1_err  = err1_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lb_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------
// Module : tb_lb_arbiter
// Cycle-table bench for lb_arbiter (TIMEOUT = 4).
// Rev    : 1.0
//----------------------------------------------------------------------
module tb_lb_arbiter;
  import lb_arb_pkg::*;

  typedef struct packed {
    logic        m0_req, m0_wr;
    logic [31:0] m0_addr, m0_wr_d;
    logic        m1_req, m1_wr;
    logic [31:0] m1_addr, m1_wr_d;
    logic [31:0] rd_d;
    logic        rdy;
  } in_t;

  typedef struct packed {
    logic        lb_wr, lb_rd;
    logic [31:0] lb_addr, lb_wr_d;
    logic        m0_ack;
    logic [31:0] m0_rd_d;
    logic        m0_err;
    logic        m1_ack;
    logic [31:0] m1_rd_d;
    logic        m1_err;
    logic        busy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk_lb;
  logic reset_l;
  logic busy;
  int   nvec;
  int   nmis;
  vec_t vq[$];

  lb_arbiter_if bus_if ();

  lb_arbiter #(
    .TO_BITS      (8),
    .TIMEOUT      (4),
    .TIMEOUT_DATA (32'hDEADBEEF)
  ) dut (
    .clk_lb  (clk_lb),
    .reset_l (reset_l),
    .bus     (bus_if),
    .busy    (busy)
  );

  initial clk_lb = 1'b0;
  always #5 clk_lb = ~clk_lb;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // f = {m0_req, m0_wr, m1_req, m1_wr, lb_rd_rdy}
  function automatic in_t ins(input logic [4:0] f, input logic [31:0] a0, d0, a1, d1, rdd);
    ins = '{f[4], f[3], a0, d0, f[2], f[1], a1, d1, rdd, f[0]};
  endfunction

  // f = {lb_wr, lb_rd, m0_ack, m0_err, m1_ack, m1_err, busy}
  function automatic out_t outs(input logic [6:0] f, input logic [31:0] addr, wd, r0, r1);
    outs = '{f[6], f[5], addr, wd, f[4], r0, f[3], f[2], r1, f[1], f[0]};
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vq.push_back(v);
  endtask

  task automatic apply(input in_t i);
    bus_if.m0_req    = i.m0_req;
    bus_if.m0_wr     = i.m0_wr;
    bus_if.m0_addr   = i.m0_addr;
    bus_if.m0_wr_d   = i.m0_wr_d;
    bus_if.m1_req    = i.m1_req;
    bus_if.m1_wr     = i.m1_wr;
    bus_if.m1_addr   = i.m1_addr;
    bus_if.m1_wr_d   = i.m1_wr_d;
    bus_if.lb_rd_d   = i.rd_d;
    bus_if.lb_rd_rdy = i.rdy;
  endtask

  task automatic check(input out_t e, input string tag);
    out_t a;
    a = '{bus_if.lb_wr, bus_if.lb_rd, bus_if.lb_addr, bus_if.lb_wr_d,
          bus_if.m0_ack, bus_if.m0_rd_d, bus_if.m0_err,
          bus_if.m1_ack, bus_if.m1_rd_d, bus_if.m1_err, busy};
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, a, e);
    end
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge
  task automatic step(input in_t i, input out_t e, input string tag);
    apply(i);
    @(posedge clk_lb);
    #1;
    check(e, tag);
    @(negedge clk_lb);
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    nvec    = 0;
    nmis    = 0;
    reset_l = 1'b0;
    apply(ins(5'b00000, Z, Z, Z, Z, Z));
    repeat (2) @(posedge clk_lb);
    #1;
    check(outs(7'b0000000, Z, Z, Z, Z), "reset");
    @(negedge clk_lb);
    reset_l = 1'b1;

    // m0 write
    add(ins(5'b11000, 'h10, 'h12345678, Z, Z, Z), outs(7'b1000001, 'h10, 'h12345678, Z, Z));
    add(ins(5'b11000, 'h10, 'h12345678, Z, Z, Z), outs(7'b0010001, 'h10, 'h12345678, Z, Z));
    add(ins(5'b00000, Z, Z, Z, Z, Z),            outs(7'b0000000, 'h10, 'h12345678, Z, Z));
    // m1 read, rdy three cycles after lb_rd; fields changed after grant
    add(ins(5'b00100, Z, Z, 'h20, 'h55, Z),      outs(7'b0100001, 'h20, 'h55, Z, Z));
    add(ins(5'b00110, Z, Z, 'h99, 'h77, Z),      outs(7'b0000001, 'h20, 'h55, Z, Z));
    add(ins(5'b00110, Z, Z, 'h99, 'h77, Z),      outs(7'b0000001, 'h20, 'h55, Z, Z));
    add(ins(5'b00110, Z, Z, 'h99, 'h77, Z),      outs(7'b0000001, 'h20, 'h55, Z, Z));
    add(ins(5'b00111, Z, Z, 'h99, 'h77, 'hA5A5A5A5), outs(7'b0000101, 'h20, 'h55, Z, 'hA5A5A5A5));
    add(ins(5'b00000, Z, Z, Z, Z, Z),            outs(7'b0000000, 'h20, 'h55, Z, Z));
    // spurious rdy in IDLE
    add(ins(5'b00001, Z, Z, Z, Z, 'hFFFFFFFF),   outs(7'b0000000, 'h20, 'h55, Z, Z));
    add(ins(5'b00001, Z, Z, Z, Z, 'hFFFFFFFF),   outs(7'b0000000, 'h20, 'h55, Z, Z));
    // m0 read, slave silent: ack six cycles after the request edge
    add(ins(5'b10000, 'h30, Z, Z, Z, Z),         outs(7'b0100001, 'h30, Z, Z, Z));
    for (int n = 0; n < 4; n++)
      add(ins(5'b10000, 'h30, Z, Z, Z, Z),       outs(7'b0000001, 'h30, Z, Z, Z));
    add(ins(5'b10000, 'h30, Z, Z, Z, Z),         outs(7'b0011001, 'h30, Z, 'hDEADBEEF, Z));
    // late rdy after timeout
    add(ins(5'b00001, Z, Z, Z, Z, 'h12121212),   outs(7'b0000000, 'h30, Z, Z, Z));
    add(ins(5'b00001, Z, Z, Z, Z, 'h12121212),   outs(7'b0000000, 'h30, Z, Z, Z));
    // both request, immediate rdy: m0 was last, so m1 then m0
    add(ins(5'b10101, 'h40, Z, 'h50, Z, 'h11111111), outs(7'b0100001, 'h50, Z, Z, Z));
    add(ins(5'b10101, 'h40, Z, 'h50, Z, 'h11111111), outs(7'b0000101, 'h50, Z, Z, 'h11111111));
    add(ins(5'b10101, 'h40, Z, 'h50, Z, 'h11111111), outs(7'b0000000, 'h50, Z, Z, Z));
    add(ins(5'b10101, 'h40, Z, 'h50, Z, 'h11111111), outs(7'b0100001, 'h40, Z, Z, Z));
    add(ins(5'b10101, 'h40, Z, 'h50, Z, 'h11111111), outs(7'b0010001, 'h40, Z, 'h11111111, Z));
    add(ins(5'b00000, Z, Z, Z, Z, Z),            outs(7'b0000000, 'h40, Z, Z, Z));

    for (int n = 0; n < vq.size(); n++)
      step(vq[n].i, vq[n].o, $sformatf("vec%0d", n));

    // Reset asserted during RD_WAIT
    step(ins(5'b10000, 'h60, Z, Z, Z, Z), outs(7'b0100001, 'h60, Z, Z, Z), "rst_issue");
    step(ins(5'b10000, 'h60, Z, Z, Z, Z), outs(7'b0000001, 'h60, Z, Z, Z), "rst_rdwait");
    reset_l = 1'b0;
    #1;
    check(outs(7'b0000000, Z, Z, Z, Z), "rst_async");
    step(ins(5'b00001, Z, Z, Z, Z, 'hABCD), outs(7'b0000000, Z, Z, Z, Z), "rst_hold");
    reset_l = 1'b1;
    step(ins(5'b00001, Z, Z, Z, Z, 'hABCD), outs(7'b0000000, Z, Z, Z, Z), "rst_rdy_idle");
    // First tie after reset goes to m0, then m1
    step(ins(5'b10101, 'h70, Z, 'h80, Z, 'h2468ACE0), outs(7'b0100001, 'h70, Z, Z, Z), "post_m0_issue");
    step(ins(5'b10101, 'h70, Z, 'h80, Z, 'h2468ACE0), outs(7'b0010001, 'h70, Z, 'h2468ACE0, Z), "post_m0_ack");
    step(ins(5'b10101, 'h70, Z, 'h80, Z, 'h2468ACE0), outs(7'b0000000, 'h70, Z, Z, Z), "post_idle");
    step(ins(5'b10101, 'h70, Z, 'h80, Z, 'h2468ACE0), outs(7'b0100001, 'h80, Z, Z, Z), "post_m1_issue");
    step(ins(5'b00101, Z, Z, 'h80, Z, 'h2468ACE0),    outs(7'b0000101, 'h80, Z, Z, 'h2468ACE0), "post_m1_ack");
    step(ins(5'b00000, Z, Z, Z, Z, Z),                outs(7'b0000000, 'h80, Z, Z, Z), "post_end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lb_arbiter.md
Name: lb_arbiter

Overview:
- Shares the single 32-bit LocalBus slave port (lb_wr/lb_rd/lb_addr/lb_wr_d/lb_rd_d/lb_rd_rdy) between two masters.
  - m0: mesa_core's LocalBus output.
  - m1: an on-chip sequencer, e.g. an autonomous SUMP2 arm/poll engine.
- Sits between the masters and core. Serialises transactions and applies round-robin fairness.
- Bounds read latency with a timeout, so a slave that never returns lb_rd_rdy cannot hang the serial link.

Parameters:
- TO_BITS, 8: width of the read-timeout counter.
- TIMEOUT, 255: RD_WAIT cycles before abort. Range 1..2^TO_BITS-1.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned on timeout.

Ports:
- clk_lb  in  1  LocalBus clock. Single clock domain.
- reset_l  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request. Held until m0_ack.
- m0_wr  in  1  1=write, 0=read.
- m0_addr  in  32  address.
- m0_wr_d  in  32  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rd_d  out  32  read data. Valid with m0_ack.
- m0_err  out  1  timeout flag. Valid with m0_ack.
- m1_req, m1_wr, m1_addr, m1_wr_d, m1_ack, m1_rd_d, m1_err: same as m0, for master 1.
- lb_wr  out  1  one-cycle write strobe to slave.
- lb_rd  out  1  one-cycle read strobe to slave.
- lb_addr  out  32  slave address.
- lb_wr_d  out  32  slave write data.
- lb_rd_d  in  32  slave read data.
- lb_rd_rdy  in  1  slave read-data valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, rr pointer set so m0 wins the first tie, timeout counter 0.
- FSM states: IDLE, ISSUE, RD_WAIT, DONE.
- IDLE:
  - Samples m0_req and m1_req.
  - Only one requesting: grant it.
  - Both requesting: grant the master not granted last (round-robin).
  - On grant, latch wr/addr/wr_d and the grant index, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle):
  - lb_wr or lb_rd is high for exactly this cycle.
  - lb_addr and lb_wr_d hold the latched values; they stay held until the next grant.
  - Write: go to DONE.
  - Read: go to RD_WAIT and clear the counter.
  - lb_rd_rdy is also sampled in this cycle; if high, go directly to DONE with lb_rd_d captured.
- RD_WAIT:
  - lb_rd_rdy=1: capture lb_rd_d, err=0, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: data=TIMEOUT_DATA, err=1, go to DONE.
- DONE (1 cycle):
  - The granted master's ack is high, with rd_d/err valid. The other master's ack stays 0.
  - Update the rr pointer, then go to IDLE.
  - Write transactions report rd_d=0 and err=0.
- Latency: req sampled high at edge k.
  - Write: lb_wr in cycle k+1, ack in cycle k+2.
  - Read with lb_rd_rdy at cycle j: ack in cycle j+1.
  - Read timeout: ack in cycle k+2+TIMEOUT.
- Handshake rules:
  - A master drops req in the cycle following its ack. A req still high in IDLE after that is a new transaction.
  - Field changes after grant are ignored.
  - A req withdrawn before grant is harmless.
- lb_rd_rdy outside ISSUE/RD_WAIT is ignored. This covers a late response after a timeout and a spurious pulse.
- lb_wr and lb_rd are never high together. At most one transaction is outstanding.
- Minimum spacing: IDLE is visited between back-to-back transactions, so strobes are at least 3 cycles apart.
- reset_l asserted mid-transaction: immediate return to reset values. No ack is issued for the aborted transaction. Any lb_rd_rdy still in flight is ignored.
- Counter never wraps: it saturates at TIMEOUT, and the abort happens at that point.

Decomposition:
- Package lb_arb_pkg holds:
  - the state encoding (localparams for IDLE/ISSUE/RD_WAIT/DONE);
  - the default TIMEOUT_DATA;
  - the LB_DW=32 and LB_AW=32 widths.
- Sub-module lb_rr_pick (combinational plus one pointer flop): takes the req vector and the last-grant pointer, produces a one-hot grant. Instantiated once. Keeps a future N-master extension local.

Test Plan:
- m0 write: m0_req=1, m0_wr=1, addr=0x10, data=0x12345678 → lb_wr=1 for 1 cycle at k+1 with those values; m0_ack at k+2; m1_ack stays 0.
- m1 read, slave rdy 3 cycles after lb_rd, lb_rd_d=0xA5A5A5A5 → m1_ack with m1_rd_d=0xA5A5A5A5, m1_err=0, 1 cycle after rdy.
- m0 and m1 requesting together continuously, reads with immediate rdy → grants alternate m0, m1, m0, m1; the first grant after reset goes to m0.
- Read, slave silent, TIMEOUT=4 → ack at k+6 with rd_d=0xDEADBEEF, err=1. A late lb_rd_rdy pulse afterwards produces no ack and no state change.
- reset_l pulsed low during RD_WAIT → all outputs 0 immediately, busy=0. The next request after reset completes normally.
- Spurious lb_rd_rdy in IDLE with no req → no ack, busy stays 0, no strobes.
